// File: rtl/tomasulo_reg_status.sv
// Tomasulo register status file.
// Holds architectural register values plus one rename tag per register.
// Operands are read with one cycle of latency, with a bypass from the CDB.
// Tag 0 means "not redirected". Broadcasts and renames with tag 0 are ignored.
// WAW safety comes from tag matching: a register renamed again never matches the older producer's broadcast.
module tomasulo_reg_status #(
  parameter int DATA_W     = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_W     = 5,
  parameter int TAG_W      = 6,
  parameter int ZERO_REG   = 1,
  parameter int INIT_INDEX = 1
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_issue,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic              i_dest_en,
  input  logic [ADDR_W-1:0] i_dest,
  input  logic [TAG_W-1:0]  i_issue_tag,
  input  logic              i_cdb_valid,
  input  logic [TAG_W-1:0]  i_cdb_tag,
  input  logic [DATA_W-1:0] i_cdb_data,
  input  logic              i_flush,
  output logic [DATA_W-1:0] o_a_out,
  output logic [DATA_W-1:0] o_b_out,
  output logic              o_a_invalid,
  output logic              o_b_invalid,
  output logic [ADDR_W:0]   o_busy_count
);

  logic [DATA_W-1:0] r_reg [NUM_REGS];
  logic [TAG_W-1:0]  r_tag [NUM_REGS];
  logic [DATA_W-1:0] r_a_out;
  logic [DATA_W-1:0] r_b_out;
  logic              r_a_invalid;
  logic              r_b_invalid;
  logic [ADDR_W:0]   r_busy_count;

  logic [DATA_W-1:0] w_reg_next [NUM_REGS];
  logic [TAG_W-1:0]  w_tag_next [NUM_REGS];
  logic [ADDR_W:0]   w_busy_next;
  logic              w_cdb_hit;
  logic              w_rename;
  logic [DATA_W:0]   w_a_read;
  logic [DATA_W:0]   w_b_read;

  // Resolve one operand from the pre-edge state, so a self-referencing
  // instruction reads the old value of its own destination.
  // The result is {invalid, value}.
  function automatic logic [DATA_W:0] readOperand(input logic [ADDR_W-1:0] addr);
    logic [DATA_W:0] result;
    result = '0;
    if ((ZERO_REG != 0) && (addr == '0)) begin
      result = '0;
    end else if (r_tag[addr] == '0) begin
      result = {1'b0, r_reg[addr]};
    end else if (w_cdb_hit && (i_cdb_tag == r_tag[addr])) begin
      result = {1'b0, i_cdb_data};
    end else begin
      result = {1'b1, DATA_W'(r_tag[addr])};
    end
    return result;
  endfunction

  // Decode the qualified CDB broadcast and the destination rename for this cycle.
  always_comb begin
    w_cdb_hit = i_cdb_valid && (i_cdb_tag != '0);
    w_rename  = i_issue && i_dest_en && (i_issue_tag != '0) &&
                !((ZERO_REG != 0) && (i_dest == '0));
  end

  // Operand lookup for both sources. A and B are resolved independently.
  always_comb begin
    w_a_read = readOperand(i_a_addr);
    w_b_read = readOperand(i_b_addr);
  end

  // Next register and tag state.
  // The CDB write comes first. Flush then clears every tag and overrides a rename.
  // Otherwise a rename to the same register wins over the CDB tag clear.
  always_comb begin
    w_busy_next = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_reg_next[i] = r_reg[i];
      w_tag_next[i] = r_tag[i];
      if (w_cdb_hit && (r_tag[i] == i_cdb_tag) &&
          !((ZERO_REG != 0) && (i == 0))) begin
        w_reg_next[i] = i_cdb_data;
        w_tag_next[i] = '0;
      end
      if (i_flush) begin
        w_tag_next[i] = '0;
      end else if (w_rename && (i_dest == ADDR_W'(i))) begin
        w_tag_next[i] = i_issue_tag;
      end
      w_busy_next = w_busy_next + {{ADDR_W{1'b0}}, (w_tag_next[i] != '0)};
    end
  end

  // State and output registers.
  // Reset takes priority over everything else.
  // The operand outputs hold their values when no issue is present.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_tag[i] <= '0;
        r_reg[i] <= (INIT_INDEX != 0) ? DATA_W'(i) : '0;
      end
      r_a_out      <= '0;
      r_b_out      <= '0;
      r_a_invalid  <= 1'b0;
      r_b_invalid  <= 1'b0;
      r_busy_count <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_tag[i] <= w_tag_next[i];
        r_reg[i] <= w_reg_next[i];
      end
      if (i_issue) begin
        r_a_out     <= w_a_read[DATA_W-1:0];
        r_a_invalid <= w_a_read[DATA_W];
        r_b_out     <= w_b_read[DATA_W-1:0];
        r_b_invalid <= w_b_read[DATA_W];
      end
      r_busy_count <= w_busy_next;
    end
  end

  assign o_a_out      = r_a_out;
  assign o_b_out      = r_b_out;
  assign o_a_invalid  = r_a_invalid;
  assign o_b_invalid  = r_b_invalid;
  assign o_busy_count = r_busy_count;

endmodule

// File: tb/tb_tomasulo_reg_status.sv
// Testbench for tomasulo_reg_status.
// The stimulus process drives directed vectors and queues hand-computed expected outputs.
// A separate monitor pops each expected entry and compares it one half cycle after the edge that produced it.
module tb_tomasulo_reg_status;

  logic        clock;
  logic        reset_n;
  logic        issue;
  logic [4:0]  aAddr;
  logic [4:0]  bAddr;
  logic        destEn;
  logic [4:0]  dest;
  logic [5:0]  issueTag;
  logic        cdbValid;
  logic [5:0]  cdbTag;
  logic [31:0] cdbData;
  logic        flush;
  logic [31:0] aOut;
  logic [31:0] bOut;
  logic        aInvalid;
  logic        bInvalid;
  logic [5:0]  busyCount;

  typedef struct {
    logic [31:0] a;
    logic        ai;
    logic [31:0] b;
    logic        bi;
    logic [5:0]  busy;
    string       name;
  } expect_t;

  expect_t expQ[$];
  int      checkCount = 0;
  int      passCount  = 0;
  int      failCount  = 0;
  logic    chkNow     = 1'b0;
  logic    chkSeen    = 1'b0;

  tomasulo_reg_status dut (
    .i_clock      (clock),
    .i_reset_n    (reset_n),
    .i_issue      (issue),
    .i_a_addr     (aAddr),
    .i_b_addr     (bAddr),
    .i_dest_en    (destEn),
    .i_dest       (dest),
    .i_issue_tag  (issueTag),
    .i_cdb_valid  (cdbValid),
    .i_cdb_tag    (cdbTag),
    .i_cdb_data   (cdbData),
    .i_flush      (flush),
    .o_a_out      (aOut),
    .o_b_out      (bOut),
    .o_a_invalid  (aInvalid),
    .o_b_invalid  (bInvalid),
    .o_busy_count (busyCount)
  );

  // Free-running clock with a 10-unit period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Record whether the cycle that is just ending produced an output to check.
  always @(posedge clock) chkSeen = chkNow;

  // Compare the outputs away from the edge against the oldest queued expectation.
  always @(negedge clock) begin
    if (chkSeen) checkOutput();
  end

  task automatic checkOutput();
    expect_t e;
    checkCount++;
    if (expQ.size() == 0) begin
      failCount++;
      $display("[TB] FAIL unexpected_output: scoreboard empty, got a=%h/%b b=%h/%b busy=%0d",
               aOut, aInvalid, bOut, bInvalid, busyCount);
    end else begin
      e = expQ.pop_front();
      if (aOut === e.a && aInvalid === e.ai && bOut === e.b &&
          bInvalid === e.bi && busyCount === e.busy) begin
        passCount++;
      end else begin
        failCount++;
        $display("[TB] FAIL %s: got a=%h/%b b=%h/%b busy=%0d, want a=%h/%b b=%h/%b busy=%0d",
                 e.name, aOut, aInvalid, bOut, bInvalid, busyCount,
                 e.a, e.ai, e.b, e.bi, e.busy);
      end
    end
  endtask

  // Drive one cycle of inputs. When chk is set, queue the outputs expected after this edge.
  task automatic applyStimulus(
    input logic        rstN,
    input logic        iss,
    input logic [4:0]  a,
    input logic [4:0]  b,
    input logic        de,
    input logic [4:0]  d,
    input logic [5:0]  itag,
    input logic        cv,
    input logic [5:0]  ct,
    input logic [31:0] cd,
    input logic        fl,
    input logic        chk,
    input logic [31:0] expA,
    input logic        expAi,
    input logic [31:0] expB,
    input logic        expBi,
    input logic [5:0]  expBusy,
    input string       name
  );
    expect_t e;
    reset_n  = rstN;
    issue    = iss;
    aAddr    = a;
    bAddr    = b;
    destEn   = de;
    dest     = d;
    issueTag = itag;
    cdbValid = cv;
    cdbTag   = ct;
    cdbData  = cd;
    flush    = fl;
    chkNow   = chk;
    if (chk) begin
      e.a = expA; e.ai = expAi; e.b = expB; e.bi = expBi; e.busy = expBusy; e.name = name;
      expQ.push_back(e);
    end
    @(posedge clock);
    #1;
    reset_n = 1'b1; issue = 1'b0; destEn = 1'b0; cdbValid = 1'b0; flush = 1'b0;
    chkNow  = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; issue = 1'b0; aAddr = '0; bAddr = '0; destEn = 1'b0; dest = '0;
    issueTag = '0; cdbValid = 1'b0; cdbTag = '0; cdbData = '0; flush = 1'b0;
    #1;
    //            rstN iss a   b   de d   itag cv ct  cdata     fl chk expA      ai expB      bi busy name
    applyStimulus(0,   1,  5,  5,  0, 0,  0,   0, 0,  0,        0, 1,  0,        0, 0,        0, 0,  "reset");
    applyStimulus(1,   1,  5,  31, 0, 0,  0,   0, 0,  0,        0, 1,  5,        0, 31,       0, 0,  "init_read");
    applyStimulus(1,   1,  0,  1,  1, 3,  7,   0, 0,  0,        0, 1,  0,        0, 1,        0, 1,  "rename_r3");
    applyStimulus(1,   1,  3,  2,  0, 0,  0,   0, 0,  0,        0, 1,  7,        1, 2,        0, 1,  "read_tag_r3");
    applyStimulus(1,   0,  0,  0,  0, 0,  0,   1, 7,  32'hDEAD, 0, 1,  7,        1, 2,        0, 0,  "cdb_hold");
    applyStimulus(1,   1,  3,  3,  0, 0,  0,   0, 0,  0,        0, 1,  32'hDEAD, 0, 32'hDEAD, 0, 0,  "r3_written");
    applyStimulus(1,   1,  0,  0,  1, 4,  9,   0, 0,  0,        0, 1,  0,        0, 0,        0, 1,  "rename_r4");
    applyStimulus(1,   1,  4,  4,  0, 0,  0,   1, 9,  32'h55,   0, 1,  32'h55,   0, 32'h55,   0, 0,  "bypass");
    applyStimulus(1,   1,  4,  5,  0, 0,  0,   0, 0,  0,        0, 1,  32'h55,   0, 5,        0, 0,  "after_bypass");
    applyStimulus(1,   1,  0,  0,  1, 2,  3,   0, 0,  0,        0, 1,  0,        0, 0,        0, 1,  "waw_first");
    applyStimulus(1,   1,  2,  0,  1, 2,  5,   0, 0,  0,        0, 1,  3,        1, 0,        0, 1,  "waw_second");
    applyStimulus(1,   1,  2,  2,  0, 0,  0,   1, 3,  32'h11,   0, 1,  5,        1, 5,        1, 1,  "waw_stale_cdb");
    applyStimulus(1,   0,  0,  0,  0, 0,  0,   1, 5,  32'h22,   0, 1,  5,        1, 5,        1, 0,  "waw_cdb_hold");
    applyStimulus(1,   1,  2,  3,  0, 0,  0,   0, 0,  0,        0, 1,  32'h22,   0, 32'hDEAD, 0, 0,  "waw_result");
    applyStimulus(1,   1,  1,  1,  1, 1,  6,   0, 0,  0,        0, 1,  1,        0, 1,        0, 1,  "self_source");
    applyStimulus(1,   1,  1,  0,  0, 0,  0,   0, 0,  0,        0, 1,  6,        1, 0,        0, 1,  "self_tag");
    applyStimulus(1,   1,  0,  1,  1, 0,  4,   0, 0,  0,        0, 1,  0,        0, 6,        1, 1,  "zero_rename");
    applyStimulus(1,   1,  0,  0,  0, 0,  0,   0, 0,  0,        0, 1,  0,        0, 0,        0, 1,  "zero_read");
    applyStimulus(1,   1,  0,  0,  1, 8,  10,  0, 0,  0,        0, 1,  0,        0, 0,        0, 2,  "rename_r8");
    applyStimulus(1,   1,  8,  9,  1, 9,  11,  0, 0,  0,        0, 1,  10,       1, 9,        0, 3,  "rename_r9");
    applyStimulus(1,   1,  8,  1,  1, 12, 13,  0, 0,  0,        1, 1,  10,       1, 6,        1, 0,  "flush_issue");
    applyStimulus(1,   1,  8,  9,  0, 0,  0,   0, 0,  0,        0, 1,  8,        0, 9,        0, 0,  "after_flush");
    applyStimulus(1,   1,  0,  0,  1, 10, 12,  0, 0,  0,        0, 1,  0,        0, 0,        0, 1,  "rename_r10");
    applyStimulus(1,   1,  10, 1,  0, 0,  0,   1, 12, 32'h77,   1, 1,  32'h77,   0, 1,        0, 0,  "flush_cdb");
    applyStimulus(1,   1,  10, 1,  0, 0,  0,   0, 0,  0,        0, 1,  32'h77,   0, 1,        0, 0,  "flush_cdb_data");
    applyStimulus(1,   1,  6,  7,  0, 0,  0,   1, 0,  32'hFF,   0, 1,  6,        0, 7,        0, 0,  "cdb_tag0");
    applyStimulus(1,   1,  6,  7,  0, 0,  0,   0, 0,  0,        0, 1,  6,        0, 7,        0, 0,  "cdb_tag0_data");
    applyStimulus(1,   1,  7,  0,  1, 7,  0,   0, 0,  0,        0, 1,  7,        0, 0,        0, 0,  "issue_tag0");
    applyStimulus(1,   1,  7,  0,  0, 0,  0,   0, 0,  0,        0, 1,  7,        0, 0,        0, 0,  "issue_tag0_read");
    applyStimulus(1,   1,  0,  0,  1, 5,  20,  0, 0,  0,        0, 1,  0,        0, 0,        0, 1,  "rename_r5");
    applyStimulus(0,   1,  5,  5,  1, 6,  21,  1, 20, 32'h99,   0, 1,  0,        0, 0,        0, 0,  "reset_mid");
    applyStimulus(1,   1,  5,  10, 0, 0,  0,   0, 0,  0,        0, 1,  5,        0, 10,       0, 0,  "after_reset");
    @(negedge clock);
    #1;
    checkCount++;
    if (expQ.size() == 0) begin
      passCount++;
    end else begin
      failCount++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, want 0", expQ.size());
    end
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
